// File: rtl/ccip_mmio_pkg.sv
// Shared CCI-P MMIO definitions: header field widths, length codes and the
// requester FSM state encoding.
package ccip_mmio_pkg;

    localparam int MMIO_TID_W   = 9;
    localparam int MMIO_ADDR_W  = 16;
    localparam int MMIO_DATA_W  = 64;
    localparam int MMIO_TIMER_W = 16;

    localparam logic [1:0] MMIO_LEN_4B = 2'b00;
    localparam logic [1:0] MMIO_LEN_8B = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE_WR,
        ISSUE_RD,
        WAIT_RSP
    } mmio_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/mmio_rsp_timer.sv
// Read-response watchdog: counts cycles while enabled and flags the last
// allowed cycle so the requester can abandon the read.
module mmio_rsp_timer
    import ccip_mmio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [MMIO_TIMER_W-1:0] LAST_COUNT = MMIO_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MMIO_TIMER_W-1:0] ONE        = MMIO_TIMER_W'(1);

    logic [MMIO_TIMER_W-1:0] count_q;

    // Holding at LAST_COUNT keeps the counter from wrapping if enable lingers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LAST_COUNT)) begin
            count_q <= count_q + ONE;
        end
    end

    assign expire_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/mmio_requester.sv
// MMIO requester: turns single read/write commands into CCI-P MMIO request
// strobes and matches read responses by tid, with timeout and stray counting.
module mmio_requester
    import ccip_mmio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [MMIO_ADDR_W-1:0] cmd_addr,
    input  logic [MMIO_DATA_W-1:0] cmd_data,
    output logic                   mmio_wr_valid,
    output logic                   mmio_rd_valid,
    output logic [MMIO_ADDR_W-1:0] req_addr,
    output logic [MMIO_TID_W-1:0]  req_tid,
    output logic [1:0]             req_length,
    output logic [MMIO_DATA_W-1:0] req_data,
    input  logic                   rsp_valid,
    input  logic [MMIO_TID_W-1:0]  rsp_tid,
    input  logic [MMIO_DATA_W-1:0] rsp_data,
    output logic                   res_valid,
    output logic [MMIO_DATA_W-1:0] res_data,
    output logic                   res_timeout,
    output logic [7:0]             stray_count
);

    mmio_state_e            state_q;
    logic                   cmd_ready_q;
    logic                   wr_valid_q;
    logic                   rd_valid_q;
    logic [MMIO_ADDR_W-1:0] req_addr_q;
    logic [MMIO_TID_W-1:0]  req_tid_q;
    logic [MMIO_DATA_W-1:0] req_data_q;
    logic [MMIO_TID_W-1:0]  tid_q;
    logic [MMIO_TID_W-1:0]  tid_d;
    logic                   res_valid_q;
    logic [MMIO_DATA_W-1:0] res_data_q;
    logic                   res_timeout_q;
    logic [7:0]             stray_count_q;
    logic [7:0]             stray_count_d;

    logic rsp_match;
    logic rsp_stray;
    logic timer_expire;

    // req_tid_q holds the tid of the outstanding read; tid_q is already the next one.
    assign rsp_match     = rsp_valid && (state_q == WAIT_RSP) && (rsp_tid == req_tid_q);
    assign rsp_stray     = rsp_valid && !rsp_match;
    assign tid_d         = tid_q + MMIO_TID_W'(1);
    assign stray_count_d = sat_inc8(stray_count_q);

    mmio_rsp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rsp_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == ISSUE_RD),
        .enable_i(state_q == WAIT_RSP),
        .expire_o(timer_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            wr_valid_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            req_addr_q    <= '0;
            req_tid_q     <= '0;
            req_data_q    <= '0;
            tid_q         <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            stray_count_q <= '0;
        end else begin
            // NOTE: strobes default low every cycle so each branch only raises them.
            wr_valid_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;

            if (rsp_stray) begin
                stray_count_q <= stray_count_d;
            end

            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        req_addr_q  <= cmd_addr;
                        if (cmd_write) begin
                            req_data_q <= cmd_data;
                            wr_valid_q <= 1'b1;
                            state_q    <= ISSUE_WR;
                        end else begin
                            req_data_q <= '0;
                            req_tid_q  <= tid_q;
                            rd_valid_q <= 1'b1;
                            state_q    <= ISSUE_RD;
                        end
                    end
                end
                ISSUE_WR: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                ISSUE_RD: begin
                    tid_q   <= tid_d;
                    state_q <= WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (rsp_match) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= rsp_data;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (timer_expire) begin
                        res_valid_q   <= 1'b1;
                        res_timeout_q <= 1'b1;
                        res_data_q    <= '0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign mmio_wr_valid = wr_valid_q;
    assign mmio_rd_valid = rd_valid_q;
    assign req_addr      = req_addr_q;
    assign req_tid       = req_tid_q;
    assign req_length    = MMIO_LEN_8B;
    assign req_data      = req_data_q;
    assign res_valid     = res_valid_q;
    assign res_data      = res_data_q;
    assign res_timeout   = res_timeout_q;
    assign stray_count   = stray_count_q;

endmodule

// File: tb/tb_mmio_requester.sv
// Directed bench for mmio_requester: a table of read/write transactions with
// hand-computed results, plus sequences for saturation, tid wrap and reset.
module tb_mmio_requester;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_data;
    logic        mmio_wr_valid;
    logic        mmio_rd_valid;
    logic [15:0] req_addr;
    logic [8:0]  req_tid;
    logic [1:0]  req_length;
    logic [63:0] req_data;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        res_valid;
    logic [63:0] res_data;
    logic        res_timeout;
    logic [7:0]  stray_count;

    mmio_requester #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .mmio_wr_valid(mmio_wr_valid),
        .mmio_rd_valid(mmio_rd_valid),
        .req_addr     (req_addr),
        .req_tid      (req_tid),
        .req_length   (req_length),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_tid      (rsp_tid),
        .rsp_data     (rsp_data),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_timeout  (res_timeout),
        .stray_count  (stray_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction: response cycles are counted from the request strobe cycle.
    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [63:0] data;
        int          d_bad;
        int          d_good;
        int          exp_lat;
        logic        exp_to;
        logic [63:0] exp_res;
        int          exp_inc;
    } vec_t;

    vec_t        vecs[8];
    int          n_tests;
    int          n_failed;
    logic [8:0]  exp_tid;
    int          exp_stray;
    logic [8:0]  last_req_tid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        exp_tid   = '0;
        exp_stray = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (cmd_ready !== 1'b1) check("wait_ready_bound", {63'd0, cmd_ready}, 64'd1);
    endtask

    task automatic run_write(input logic [15:0] addr, input logic [63:0] data);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = addr;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        check("wr_strobe", {63'd0, mmio_wr_valid}, 64'd1);
        check("wr_no_rd", {63'd0, mmio_rd_valid}, 64'd0);
        check("wr_busy", {63'd0, cmd_ready}, 64'd0);
        check("wr_addr", {48'd0, req_addr}, {48'd0, addr});
        check("wr_data", req_data, data);
        step();
        check("wr_strobe_end", {63'd0, mmio_wr_valid}, 64'd0);
        check("wr_ready_back", {63'd0, cmd_ready}, 64'd1);
        check("wr_stray", {56'd0, stray_count}, 64'(exp_stray));
    endtask

    task automatic run_read(input logic [15:0] addr, input logic [63:0] rdata,
                            input int d_bad, input int d_good, input int exp_lat,
                            input logic exp_to, input logic [63:0] exp_res,
                            input int exp_inc);
        logic [8:0] tid_used;
        int         lat;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = addr;
        cmd_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        cmd_valid = 1'b0;
        check("rd_strobe", {63'd0, mmio_rd_valid}, 64'd1);
        check("rd_no_wr", {63'd0, mmio_wr_valid}, 64'd0);
        check("rd_busy", {63'd0, cmd_ready}, 64'd0);
        check("rd_addr", {48'd0, req_addr}, {48'd0, addr});
        check("rd_tid", {55'd0, req_tid}, {55'd0, exp_tid});
        check("rd_data_zero", req_data, 64'd0);
        check("rd_length", {62'd0, req_length}, 64'd1);
        last_req_tid = req_tid;
        tid_used     = exp_tid;
        exp_tid      = exp_tid + 9'd1;
        lat          = 0;
        for (int c = 1; c <= TMO + 4 && lat == 0; c++) begin
            step();
            rsp_valid = 1'b0;
            if (c == 1) check("rd_strobe_end", {63'd0, mmio_rd_valid}, 64'd0);
            if (c == d_bad) begin
                rsp_valid = 1'b1;
                rsp_tid   = tid_used ^ 9'h001;
                rsp_data  = ~rdata;
            end
            if (c == d_good) begin
                rsp_valid = 1'b1;
                rsp_tid   = tid_used;
                rsp_data  = rdata;
            end
            if (res_valid === 1'b1) lat = c;
        end
        check("res_latency", 64'(lat), 64'(exp_lat));
        check("res_timeout", {63'd0, res_timeout}, {63'd0, exp_to});
        check("res_data", res_data, exp_res);
        check("res_ready", {63'd0, cmd_ready}, 64'd1);
        step();
        rsp_valid = 1'b0;
        exp_stray = exp_stray + exp_inc;
        check("res_pulse_end", {63'd0, res_valid}, 64'd0);
        check("rd_stray", {56'd0, stray_count}, 64'(exp_stray));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        n_tests   = 0;
        n_failed  = 0;
        exp_tid   = '0;
        exp_stray = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_valid = 1'b0;
        rsp_tid   = '0;
        rsp_data  = '0;

        vecs[0] = '{1'b1, 16'h0020, 64'hDEADBEEF_CAFEF00D, -1, -1, 0, 1'b0, 64'h0, 0};
        vecs[1] = '{1'b0, 16'h0000, 64'h1000_0000_0000_0000, -1, 3, 4, 1'b0, 64'h1000_0000_0000_0000, 0};
        vecs[2] = '{1'b0, 16'h1234, 64'h0, -1, -1, TMO + 1, 1'b1, 64'h0, 0};
        vecs[3] = '{1'b0, 16'hFFFF, 64'hA5A5_A5A5_5A5A_5A5A, -1, TMO, TMO + 1, 1'b0, 64'hA5A5_A5A5_5A5A_5A5A, 0};
        vecs[4] = '{1'b0, 16'h0042, 64'h0123_4567_89AB_CDEF, -1, 1, 2, 1'b0, 64'h0123_4567_89AB_CDEF, 0};
        vecs[5] = '{1'b0, 16'h0100, 64'h7777_0000_7777_0000, -1, TMO + 1, TMO + 1, 1'b1, 64'h0, 1};
        vecs[6] = '{1'b1, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1, 0, 1'b0, 64'h0, 0};
        vecs[7] = '{1'b0, 16'h0008, 64'h1111_2222_3333_4444, 2, -1, TMO + 1, 1'b1, 64'h0, 1};

        step();
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_wr_valid", {63'd0, mmio_wr_valid}, 64'd0);
        check("rst_rd_valid", {63'd0, mmio_rd_valid}, 64'd0);
        check("rst_req_addr", {48'd0, req_addr}, 64'd0);
        check("rst_req_tid", {55'd0, req_tid}, 64'd0);
        check("rst_req_data", req_data, 64'd0);
        check("rst_req_length", {62'd0, req_length}, 64'd1);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_timeout", {63'd0, res_timeout}, 64'd0);
        check("rst_res_data", res_data, 64'd0);
        check("rst_stray", {56'd0, stray_count}, 64'd0);
        reset_dut();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].write)
                run_write(vecs[i].addr, vecs[i].data);
            else
                run_read(vecs[i].addr, vecs[i].data, vecs[i].d_bad, vecs[i].d_good,
                         vecs[i].exp_lat, vecs[i].exp_to, vecs[i].exp_res, vecs[i].exp_inc);
        end

        // Mismatched tid first, then the right one, inside the same wait window.
        reset_dut();
        run_read(16'h0010, 64'hCAFE_0000_0000_BEEF, 1, 3, 4, 1'b0, 64'hCAFE_0000_0000_BEEF, 1);
        check("stray_then_match", {56'd0, stray_count}, 64'd1);

        // Continuous responses while idle saturate the stray counter.
        rsp_valid = 1'b1;
        rsp_tid   = 9'd0;
        rsp_data  = 64'h5555;
        repeat (253) step();
        check("stray_254", {56'd0, stray_count}, 64'd254);
        repeat (47) step();
        check("stray_sat_255", {56'd0, stray_count}, 64'd255);
        rsp_valid = 1'b0;
        step();
        check("stray_sat_hold", {56'd0, stray_count}, 64'd255);

        // 513 reads walk tid through 0..511 and back to 0.
        reset_dut();
        for (int i = 0; i < 513; i++) begin
            run_read(16'(i), 64'(i) + 64'h100, -1, 1, 2, 1'b0, 64'(i) + 64'h100, 0);
        end
        check("wrap_last_tid", {55'd0, last_req_tid}, 64'd0);

        // Reset while waiting abandons the read; a late response is stray.
        reset_dut();
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0ABC;
        step();
        cmd_valid = 1'b0;
        check("rstmid_strobe", {63'd0, mmio_rd_valid}, 64'd1);
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_async_res", {63'd0, res_valid}, 64'd0);
        check("rstmid_async_ready", {63'd0, cmd_ready}, 64'd1);
        step();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < TMO + 4; c++) begin
            step();
            if (res_valid === 1'b1) seen++;
        end
        check("rstmid_no_res", 64'(seen), 64'd0);
        check("rstmid_ready", {63'd0, cmd_ready}, 64'd1);
        rsp_valid = 1'b1;
        rsp_tid   = 9'd0;
        rsp_data  = 64'h0BAD;
        step();
        rsp_valid = 1'b0;
        step();
        check("rstmid_late_stray", {56'd0, stray_count}, 64'd1);
        check("rstmid_late_no_res", {63'd0, res_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
